// File: rtl/axi3_gp_slave_regs.sv
// AXI3 slave register bank for the Zynq PS GP master port.
// Independent write/read FSMs, byte strobes, per-beat SLVERR, flat register export.
module axi3_gp_slave_regs #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ID_W      = 12,
  parameter int unsigned       N_REGS    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h4000_0000
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [ID_W-1:0]          awid,
  input  logic [ADDR_W-1:0]        awaddr,
  input  logic [3:0]               awlen,
  input  logic [2:0]               awsize,
  input  logic [1:0]               awburst,
  input  logic [1:0]               awlock,
  input  logic [3:0]               awcache,
  input  logic [2:0]               awprot,
  input  logic [3:0]               awqos,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [ID_W-1:0]          wid,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wstrb,
  input  logic                     wlast,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [ID_W-1:0]          bid,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ID_W-1:0]          arid,
  input  logic [ADDR_W-1:0]        araddr,
  input  logic [3:0]               arlen,
  input  logic [2:0]               arsize,
  input  logic [1:0]               arburst,
  input  logic [1:0]               arlock,
  input  logic [3:0]               arcache,
  input  logic [2:0]               arprot,
  input  logic [3:0]               arqos,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [ID_W-1:0]          rid,
  output logic [DATA_W-1:0]        rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [N_REGS*DATA_W-1:0] regs_q
);

  localparam int unsigned       STRB_W = DATA_W / 8;
  localparam int unsigned       LSB    = $clog2(STRB_W);
  localparam int unsigned       IDX_W  = $clog2(N_REGS);
  localparam logic [ADDR_W-1:0] SPAN   = ADDR_W'(N_REGS * STRB_W);

  typedef enum logic [1:0] {StWIdle, StWData, StWResp} w_state_e;
  typedef enum logic       {StRIdle, StRData}          r_state_e;

  // WRAP, reserved bursts and oversize beats poison the whole burst.
  function automatic logic req_bad(input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'(LSB)) || burst[1];
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (addr - BASE_ADDR) < SPAN;
  endfunction

  function automatic logic [IDX_W-1:0] reg_idx(input logic [ADDR_W-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> LSB);
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [2:0] size,
                                                  input logic [1:0] burst);
    return (burst == 2'b01) ? addr + (ADDR_W'(1) << size) : addr;
  endfunction

  logic unused_ok;
  assign unused_ok = ^{awlock, awcache, awprot, awqos, arlock, arcache, arprot, arqos, wid};

  // ---------------- write channel ----------------
  w_state_e          w_state_q;
  logic [ID_W-1:0]   w_id_q, bid_q;
  logic [ADDR_W-1:0] w_addr_q;
  logic [3:0]        w_len_q, w_beat_q;
  logic [2:0]        w_size_q;
  logic [1:0]        w_burst_q, bresp_q;
  logic              w_bad_q, w_err_q, awready_q, wready_q, bvalid_q;
  logic              w_hs, w_final, w_ok, w_beat_err;
  logic [IDX_W-1:0]  w_idx;

  assign w_hs       = wvalid & wready_q;
  assign w_final    = (w_beat_q == w_len_q);
  assign w_ok       = !w_bad_q && in_range(w_addr_q);
  assign w_beat_err = !w_ok || (wlast != w_final);
  assign w_idx      = reg_idx(w_addr_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= StWIdle;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_bad_q   <= 1'b0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      unique case (w_state_q)
        StWIdle: begin
          if (awvalid && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_id_q    <= awid;
            w_addr_q  <= awaddr;
            w_len_q   <= awlen;
            w_size_q  <= awsize;
            w_burst_q <= awburst;
            w_bad_q   <= req_bad(awsize, awburst);
            w_err_q   <= req_bad(awsize, awburst);
            w_beat_q  <= '0;
            w_state_q <= StWData;
          end else begin
            awready_q <= 1'b1;
          end
        end
        StWData: begin
          if (w_hs) begin
            w_beat_q <= w_beat_q + 4'd1;
            w_addr_q <= next_addr(w_addr_q, w_size_q, w_burst_q);
            // The beat count, not wlast, terminates the burst.
            if (w_final) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bid_q     <= w_id_q;
              bresp_q   <= (w_err_q || w_beat_err) ? 2'b10 : 2'b00;
              w_state_q <= StWResp;
            end else begin
              w_err_q <= w_err_q | w_beat_err;
            end
          end
        end
        StWResp: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= StWIdle;
          end
        end
        default: w_state_q <= StWIdle;
      endcase
    end
  end

  logic [DATA_W-1:0] reg_file_q [N_REGS];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < N_REGS; i++) reg_file_q[i] <= '0;
    end else if (w_hs && w_ok) begin
      for (int unsigned k = 0; k < STRB_W; k++) begin
        if (wstrb[k]) reg_file_q[w_idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_export
    assign regs_q[g*DATA_W +: DATA_W] = reg_file_q[g];
  end

  // ---------------- read channel ----------------
  r_state_e          r_state_q;
  logic [ID_W-1:0]   rid_q;
  logic [ADDR_W-1:0] r_addr_q, r_nxt_addr;
  logic [3:0]        r_len_q, r_beat_q;
  logic [2:0]        r_size_q;
  logic [1:0]        r_burst_q, rresp_q;
  logic              r_bad_q, arready_q, rvalid_q, rlast_q, r_nxt_bad, r_nxt_ok;
  logic [DATA_W-1:0] rdata_q, r_nxt_data;

  // Data for the beat about to be presented; sampled before any same-edge write.
  always_comb begin
    if (r_state_q == StRIdle) begin
      r_nxt_addr = araddr;
      r_nxt_bad  = req_bad(arsize, arburst);
    end else begin
      r_nxt_addr = next_addr(r_addr_q, r_size_q, r_burst_q);
      r_nxt_bad  = r_bad_q;
    end
    r_nxt_ok   = !r_nxt_bad && in_range(r_nxt_addr);
    r_nxt_data = r_nxt_ok ? reg_file_q[reg_idx(r_nxt_addr)] : '0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= StRIdle;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_bad_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      unique case (r_state_q)
        StRIdle: begin
          if (arvalid && arready_q) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rid_q     <= arid;
            r_addr_q  <= araddr;
            r_len_q   <= arlen;
            r_size_q  <= arsize;
            r_burst_q <= arburst;
            r_bad_q   <= r_nxt_bad;
            r_beat_q  <= '0;
            rdata_q   <= r_nxt_data;
            rresp_q   <= r_nxt_ok ? 2'b00 : 2'b10;
            rlast_q   <= (arlen == 4'd0);
            r_state_q <= StRData;
          end else begin
            arready_q <= 1'b1;
          end
        end
        StRData: begin
          if (rready) begin
            if (r_beat_q == r_len_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= StRIdle;
            end else begin
              r_beat_q <= r_beat_q + 4'd1;
              r_addr_q <= r_nxt_addr;
              rdata_q  <= r_nxt_data;
              rresp_q  <= r_nxt_ok ? 2'b00 : 2'b10;
              rlast_q  <= ((r_beat_q + 4'd1) == r_len_q);
            end
          end
        end
        default: r_state_q <= StRIdle;
      endcase
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

endmodule

// File: tb/tb_axi3_gp_slave_regs.sv
// Self-checking bench for axi3_gp_slave_regs: directed scenarios plus randomized
// bursts compared against a per-beat address/byte model of the register bank.
module tb_axi3_gp_slave_regs;
  localparam int unsigned AW = 32, DW = 32, IW = 12, NR = 16;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic aclk, aresetn;
  logic [IW-1:0] awid, wid, bid, arid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [3:0] awlen, arlen, awcache, arcache, awqos, arqos;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, awlock, arlock, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [NR*DW-1:0] regs_q;

  axi3_gp_slave_regs #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .N_REGS(NR),
                       .BASE_ADDR(BASE)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .regs_q(regs_q)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int tests = 0;
  int fails = 0;
  logic [31:0] model [NR];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd [16];
  logic [1:0]  rr [16];
  logic        rl [16];
  logic [IW-1:0] got_bid, got_rid;
  logic [1:0] got_bresp;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0: return awready;
      1: return wready;
      2: return bvalid;
      3: return arready;
      4: return rvalid;
      default: return 1'b0;
    endcase
  endfunction

  // Bounded wait, sampled on the falling edge; an expired bound is a failed check.
  task automatic wait_sig(input int w, input string name);
    int n = 0;
    @(negedge aclk);
    while (!sig(w) && n < 200) begin
      @(negedge aclk);
      n++;
    end
    check({"wait ", name}, 64'(sig(w)), 64'd1);
  endtask

  // ---- reference model: each beat's address from the burst rules directly ----
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst, input int k);
    return (burst == 2'b00) ? a : a + 32'(k) * (32'd1 << size);
  endfunction

  function automatic logic beat_ok(input logic [31:0] a, input logic [2:0] size,
                                   input logic [1:0] burst);
    logic [31:0] off;
    off = a - BASE;
    return (burst < 2'd2) && (size <= 3'd2) && (off < 32'd64);
  endfunction

  function automatic int ridx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off / 4) % NR;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int last_at,
                             output logic [1:0] exp_resp);
    logic err = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      logic [31:0] ba;
      ba = beat_addr(a, size, burst, k);
      if (beat_ok(ba, size, burst)) begin
        for (int b = 0; b < 4; b++)
          if (ws[k][b]) model[ridx(ba)][8*b +: 8] = wd[k][8*b +: 8];
      end else begin
        err = 1'b1;
      end
      if ((k == last_at) != (k == int'(len))) err = 1'b1;
    end
    exp_resp = err ? 2'b10 : 2'b00;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++)
      check($sformatf("%s regs_q[%0d]", tag, i), 64'(regs_q[i*32 +: 32]), 64'(model[i]));
  endtask

  task automatic check_read(input string tag, input logic [31:0] a, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [IW-1:0] id);
    check({tag, " rid"}, 64'(got_rid), 64'(id));
    for (int k = 0; k <= int'(len); k++) begin
      logic [31:0] ba;
      logic ok;
      ba = beat_addr(a, size, burst, k);
      ok = beat_ok(ba, size, burst);
      check($sformatf("%s rdata[%0d]", tag, k), 64'(rd[k]), ok ? 64'(model[ridx(ba)]) : 64'd0);
      check($sformatf("%s rresp[%0d]", tag, k), 64'(rr[k]), ok ? 64'd0 : 64'd2);
      check($sformatf("%s rlast[%0d]", tag, k), 64'(rl[k]), 64'(k == int'(len)));
    end
  endtask

  // ---- bus drivers ----
  task automatic aw_send(input logic [IW-1:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    wait_sig(0, "awready");
    @(posedge aclk); #1 awvalid = 1'b0;
  endtask

  task automatic axi_write(input logic [IW-1:0] id, input logic [31:0] a, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int last_at);
    aw_send(id, a, len, size, burst);
    for (int k = 0; k <= int'(len); k++) begin
      wvalid = 1'b1; wdata = wd[k]; wstrb = ws[k]; wlast = (k == last_at);
      wait_sig(1, "wready");
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    wait_sig(2, "bvalid");
    got_bid = bid; got_bresp = bresp;
    @(posedge aclk); #1 bready = 1'b0;
  endtask

  task automatic axi_read(input logic [IW-1:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [15:0] stall);
    arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    wait_sig(3, "arready");
    @(posedge aclk); #1 arvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      rready = !stall[k];
      wait_sig(4, "rvalid");
      if (stall[k]) begin
        logic [31:0] hd;
        logic hl;
        hd = rdata; hl = rlast;
        @(posedge aclk); #1 rready = 1'b1;
        @(negedge aclk);
        check($sformatf("stall rdata[%0d]", k), 64'(rdata), 64'(hd));
        check($sformatf("stall rlast[%0d]", k), 64'(rlast), 64'(hl));
      end
      rd[k] = rdata; rr[k] = rresp; rl[k] = rlast; got_rid = rid;
      @(posedge aclk); #1;
    end
    rready = 1'b0;
  endtask

  initial begin
    logic [1:0] eb;
    logic [31:0] a, old;
    logic [3:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic seen;
    int last_at;

    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    awlock = '0; awcache = '0; awprot = '0; awqos = '0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    arlock = '0; arcache = '0; arprot = '0; arqos = '0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0; rready = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst awready", 64'(awready), 64'd0);
    check("rst arready", 64'(arready), 64'd0);
    check("rst bvalid", 64'(bvalid), 64'd0);
    check("rst rvalid", 64'(rvalid), 64'd0);
    check("rst rlast", 64'(rlast), 64'd0);
    check("rst bid", 64'(bid), 64'd0);
    check("rst rid", 64'(rid), 64'd0);
    check("rst rdata", 64'(rdata), 64'd0);
    check_regs("rst");
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;
    check("post-rst awready", 64'(awready), 64'd1);
    check("post-rst arready", 64'(arready), 64'd1);

    // Single write then read
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    axi_write(12'h123, 32'h4000_0008, 4'd0, 3'd2, 2'b01, 0);
    model_write(32'h4000_0008, 4'd0, 3'd2, 2'b01, 0, eb);
    check("single bid", 64'(got_bid), 64'h123);
    check("single bresp", 64'(got_bresp), 64'(eb));
    check("single regs_q[95:64]", 64'(regs_q[95:64]), 64'hDEAD_BEEF);
    axi_read(12'h456, 32'h4000_0008, 4'd0, 3'd2, 2'b01, 16'h0);
    check_read("single", 32'h4000_0008, 4'd0, 3'd2, 2'b01, 12'h456);

    // INCR burst, read back with rready toggling 1,0,1,0
    for (int k = 0; k < 4; k++) begin wd[k] = 32'(k + 1); ws[k] = 4'hF; end
    axi_write(12'h7, BASE, 4'd3, 3'd2, 2'b01, 3);
    model_write(BASE, 4'd3, 3'd2, 2'b01, 3, eb);
    check("incr bresp", 64'(got_bresp), 64'(eb));
    check_regs("incr");
    axi_read(12'h8, BASE, 4'd3, 3'd2, 2'b01, 16'b1010);
    check_read("incr", BASE, 4'd3, 3'd2, 2'b01, 12'h8);

    // Strobes and FIXED
    wd[0] = 32'h1122_3344; ws[0] = 4'hF;
    axi_write(12'h1, BASE, 4'd0, 3'd2, 2'b01, 0);
    model_write(BASE, 4'd0, 3'd2, 2'b01, 0, eb);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'h5;
    axi_write(12'h2, BASE, 4'd0, 3'd2, 2'b01, 0);
    model_write(BASE, 4'd0, 3'd2, 2'b01, 0, eb);
    check("strobe reg0", 64'(regs_q[31:0]), 64'h11BB_33DD);
    for (int k = 0; k < 3; k++) begin wd[k] = 32'(k + 5); ws[k] = 4'hF; end
    axi_write(12'h3, 32'h4000_0004, 4'd2, 3'd2, 2'b00, 2);
    model_write(32'h4000_0004, 4'd2, 3'd2, 2'b00, 2, eb);
    check("fixed reg1", 64'(regs_q[63:32]), 64'd7);
    check_regs("fixed");

    // Errors
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    axi_write(12'h9, 32'h4000_0040, 4'd0, 3'd2, 2'b01, 0);
    check("oor bresp", 64'(got_bresp), 64'd2);
    check_regs("oor");
    wd[0] = 32'hCAFE_0001; wd[1] = 32'hCAFE_0002; ws[0] = 4'hF; ws[1] = 4'hF;
    axi_write(12'hA, 32'h4000_003C, 4'd1, 3'd2, 2'b01, 1);
    model_write(32'h4000_003C, 4'd1, 3'd2, 2'b01, 1, eb);
    check("cross bresp", 64'(got_bresp), 64'd2);
    check("cross reg15", 64'(regs_q[511:480]), 64'hCAFE_0001);
    axi_read(12'hB, BASE, 4'd3, 3'd2, 2'b10, 16'h0);
    check_read("wrap", BASE, 4'd3, 3'd2, 2'b10, 12'hB);
    for (int k = 0; k < 4; k++) begin wd[k] = 32'(k + 100); ws[k] = 4'hF; end
    axi_write(12'hC, 32'h4000_0010, 4'd3, 3'd2, 2'b01, 1);
    model_write(32'h4000_0010, 4'd3, 3'd2, 2'b01, 1, eb);
    check("early wlast bresp", 64'(got_bresp), 64'd2);
    check_regs("early wlast");

    // Randomized bursts
    for (int t = 0; t < 40; t++) begin
      int bsel;
      a = BASE + 32'($urandom_range(0, 32'h4F));
      len = 4'($urandom_range(0, 7));
      size = 3'($urandom_range(0, 3));
      bsel = $urandom_range(0, 9);
      burst = (bsel < 5) ? 2'b01 : (bsel < 8) ? 2'b00 : (bsel == 8) ? 2'b10 : 2'b11;
      last_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, int'(len)) : int'(len);
      for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom); end
      axi_write(12'($urandom), a, len, size, burst, last_at);
      model_write(a, len, size, burst, last_at, eb);
      check($sformatf("rand%0d bresp", t), 64'(got_bresp), 64'(eb));
      check_regs($sformatf("rand%0d", t));
      a = BASE + 32'($urandom_range(0, 32'h4F));
      len = 4'($urandom_range(0, 7));
      burst = ($urandom_range(0, 4) == 0) ? 2'b00 : 2'b01;
      axi_read(12'(t), a, len, 3'($urandom_range(0, 2)), burst, 16'($urandom));
      check_read($sformatf("rand%0d", t), a, len, arsize, burst, 12'(t));
    end

    // Same-cycle write and read of one register
    wd[0] = 32'h1234_5678; ws[0] = 4'hF;
    axi_write(12'h1, 32'h4000_0008, 4'd0, 3'd2, 2'b01, 0);
    model_write(32'h4000_0008, 4'd0, 3'd2, 2'b01, 0, eb);
    old = model[2];
    aw_send(12'h5, 32'h4000_0008, 4'd0, 3'd2, 2'b01);
    wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; wlast = 1'b1;
    arid = 12'h9; araddr = 32'h4000_0008; arlen = 4'd0; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1;
    wait_sig(1, "conc wready");
    check("conc arready", 64'(arready), 64'd1);
    @(posedge aclk); #1 wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    rready = 1'b1;
    wait_sig(4, "conc rvalid");
    check("conc old rdata", 64'(rdata), 64'(old));
    check("conc rid", 64'(rid), 64'h9);
    @(posedge aclk); #1 rready = 1'b0;
    bready = 1'b1;
    wait_sig(2, "conc bvalid");
    check("conc bid", 64'(bid), 64'h5);
    check("conc bresp", 64'(bresp), 64'd0);
    @(posedge aclk); #1 bready = 1'b0;
    wd[0] = 32'h55;
    model_write(32'h4000_0008, 4'd0, 3'd2, 2'b01, 0, eb);
    axi_read(12'hE, 32'h4000_0008, 4'd0, 3'd2, 2'b01, 16'h0);
    check_read("conc new", 32'h4000_0008, 4'd0, 3'd2, 2'b01, 12'hE);

    // Reset during beat 2 of a 4-beat write
    aw_send(12'h3, BASE, 4'd3, 3'd2, 2'b01);
    for (int k = 0; k < 2; k++) begin
      wvalid = 1'b1; wdata = 32'hA0 + 32'(k); wstrb = 4'hF; wlast = 1'b0;
      wait_sig(1, "midrst wready");
      @(posedge aclk); #1;
    end
    wdata = 32'hA2;
    @(negedge aclk) aresetn = 1'b0;
    #1;
    wvalid = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    check("midrst awready", 64'(awready), 64'd0);
    check("midrst wready", 64'(wready), 64'd0);
    check_regs("midrst");
    seen = 1'b0;
    repeat (3) @(negedge aclk) seen |= bvalid | rvalid;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("midrst awready after release", 64'(awready), 64'd1);
    check("midrst arready after release", 64'(arready), 64'd1);
    repeat (10) @(negedge aclk) seen |= bvalid | rvalid;
    check("midrst no B/R beat", 64'(seen), 64'd0);
    check_regs("midrst after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
